// File: rtl/debug_slave_ctrl.sv
// debug_slave_ctrl: JTAG-style debug data-register slave.
// An instruction latched on update_ir selects one of NUM_CH capture words.
// The word is loaded into a DR_WIDTH shift register on capture_en and shifted
// LSB-first out of tdo while tdi fills from the top. update_dr then commits it
// to jdo one cycle later and raises a one-cycle take_action or take_no_action
// pulse on the selected channel. The pulse type is set by the committed MSB.
// Optional build macro DEBUG_SLAVE_CTRL_SCAN_CHECK_EN adds a shift-bit counter.
// With it, a commit after fewer than DR_WIDTH shifts still updates jdo, but it
// suppresses the pulse and sets the sticky err_short flag.
module debug_slave_ctrl #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int NUM_CH   = 4    // must equal 2**IR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic                       update_ir,
  input  logic                       capture_en,
  input  logic                       shift_en,
  input  logic                       update_dr,
  input  logic                       tdi,
  input  logic [NUM_CH*DR_WIDTH-1:0] cap_data,
  output logic                       tdo,
  output logic [DR_WIDTH-1:0]        jdo,
  output logic [IR_WIDTH-1:0]        ir_q,
  output logic [NUM_CH-1:0]          take_action,
  output logic [NUM_CH-1:0]          take_no_action,
  output logic                       busy,
  output logic                       err_short
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [DR_WIDTH-1:0] sr;
  logic [DR_WIDTH-1:0] cap_sel;
  logic [NUM_CH-1:0]   ch_onehot;
  logic                do_capture;
  logic                do_shift;
  logic                do_commit;
  logic                short_scan;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential logic uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and strobe qualification.
  // The priority order is capture_en > update_dr > shift_en.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    state_nxt  = state;
    do_capture = 1'b0;
    do_shift   = 1'b0;
    do_commit  = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (capture_en) begin
          do_capture = 1'b1;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (capture_en) begin
          do_capture = 1'b1;            // restart the scan with fresh data
        end else if (update_dr) begin
          state_nxt  = UPDATE;
        end else if (shift_en) begin
          do_shift   = 1'b1;
        end
      end
      UPDATE: begin
        do_commit = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture word mux, indexed by the latched instruction.
  always_comb begin
    cap_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ir_q == IR_WIDTH'(k)) cap_sel = cap_data[k*DR_WIDTH +: DR_WIDTH];
    end
  end

  assign ch_onehot = NUM_CH'(1) << ir_q;

  // Instruction latch, shift register, commit register and action pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q           <= '0;
      sr             <= '0;
      tdo            <= 1'b0;
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (update_ir) ir_q <= ir_in;
      if (do_capture) begin
        sr <= cap_sel;
      end else if (do_shift) begin
        sr  <= {tdi, sr[DR_WIDTH-1:1]};
        tdo <= sr[0];
      end
      if (do_commit) begin
        jdo <= sr;
        if (!short_scan) begin
          if (sr[DR_WIDTH-1]) take_action    <= ch_onehot;
          else                take_no_action <= ch_onehot;
        end
      end
    end
  end

`ifdef DEBUG_SLAVE_CTRL_SCAN_CHECK_EN
  localparam int CNT_W = $clog2(DR_WIDTH + 1);

  logic [CNT_W-1:0] bit_cnt;

  assign short_scan = (bit_cnt < CNT_W'(DR_WIDTH));

  // Shift-bit counter, saturating at DR_WIDTH; cleared by every capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    bit_cnt <= '0;
    else if (do_capture)                          bit_cnt <= '0;
    else if (do_shift && !(bit_cnt == CNT_W'(DR_WIDTH))) bit_cnt <= bit_cnt + 1'b1;
  end

  // Sticky short-scan flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        err_short <= 1'b0;
    else if (do_commit && short_scan) err_short <= 1'b1;
  end
`else
  assign short_scan = 1'b0;
  assign err_short  = 1'b0;
`endif

endmodule

// File: tb/tb_debug_slave_ctrl.sv
// Bench for debug_slave_ctrl with directed vectors and a scoreboard.
// Each commit, and each reset that aborts a scan, pushes its expected
// jdo/pulse/err_short record onto a queue. A negedge monitor pops the record
// when busy falls and compares it against the outputs. The monitor also flags
// any pulse that appears at another time, or that is not one-hot.
module tb_debug_slave_ctrl;

  localparam int IR_W = 2;
  localparam int DR_W = 38;
  localparam int NCH  = 4;

  logic                  clk;
  logic                  reset;
  logic [IR_W-1:0]       ir_in;
  logic                  update_ir, capture_en, shift_en, update_dr, tdi;
  logic [NCH*DR_W-1:0]   cap_data;
  logic                  tdo;
  logic [DR_W-1:0]       jdo;
  logic [IR_W-1:0]       ir_q;
  logic [NCH-1:0]        take_action, take_no_action;
  logic                  busy, err_short;

  typedef struct {
    logic [NCH-1:0]  ta;
    logic [NCH-1:0]  tna;
    logic [DR_W-1:0] jdo;
    logic            err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  logic prev_busy = 1'b0;
  logic exp_err   = 1'b0;
  logic [DR_W-1:0] stream;

  localparam logic [DR_W-1:0] CH0 = 38'h2A_AAAA_AAAA;
  localparam logic [DR_W-1:0] CH1 = 38'h15_5555_5555;
  localparam logic [DR_W-1:0] CH2 = 38'h00_0000_0000;
  localparam logic [DR_W-1:0] CH3 = 38'h00_0000_0000;
  localparam logic [DR_W-1:0] ONES = 38'h3F_FFFF_FFFF;

  debug_slave_ctrl #(.IR_WIDTH(IR_W), .DR_WIDTH(DR_W), .NUM_CH(NCH)) dut (
    .clk            (clk),
    .reset          (reset),
    .ir_in          (ir_in),
    .update_ir      (update_ir),
    .capture_en     (capture_en),
    .shift_en       (shift_en),
    .update_dr      (update_dr),
    .tdi            (tdi),
    .cap_data       (cap_data),
    .tdo            (tdo),
    .jdo            (jdo),
    .ir_q           (ir_q),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .busy           (busy),
    .err_short      (err_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of strobes, then return them to zero.
  task automatic cyc(input logic cap, input logic sh, input logic upd, input logic td,
                     input logic uir, input logic [IR_W-1:0] irv);
    capture_en = cap; shift_en = sh; update_dr = upd; tdi = td;
    update_ir = uir; ir_in = irv;
    @(posedge clk); #1;
    capture_en = 1'b0; shift_en = 1'b0; update_dr = 1'b0; tdi = 1'b0;
    update_ir = 1'b0; ir_in = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, '0);
  endtask

  task automatic push(input logic [NCH-1:0] ta, input logic [NCH-1:0] tna,
                      input logic [DR_W-1:0] j, input logic e);
    exp_t r;
    r.ta = ta; r.tna = tna; r.jdo = j; r.err = e;
    sb.push_back(r);
  endtask

  // Monitor: a falling busy marks the end of a scan (commit or reset abort).
  initial begin
    forever begin
      @(negedge clk);
      if (prev_busy && !busy) begin
        check("commit_expected", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("take_action",    take_action,    mon_e.ta);
          check("take_no_action", take_no_action, mon_e.tna);
          check("jdo",            jdo,            mon_e.jdo);
          check("err_short",      err_short,      mon_e.err);
        end
      end else if ((take_action | take_no_action) != '0) begin
        check("spurious_pulse", take_action | take_no_action, 0);
      end
      if ((take_action | take_no_action) != '0)
        check("pulse_onehot", 64'($countones(take_action | take_no_action) <= 1), 1);
      prev_busy = busy;
    end
  end

  initial begin
    reset = 1'b1;
    capture_en = 1'b0; shift_en = 1'b0; update_dr = 1'b0; tdi = 1'b0;
    update_ir = 1'b0; ir_in = '0;
    cap_data = {CH3, CH2, CH1, CH0};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Quiet after reset release: everything at zero.
    idle(10);
    check("rst_tdo", tdo, 0);
    check("rst_jdo", jdo, 0);
    check("rst_ir_q", ir_q, 0);
    check("rst_take_action", take_action, 0);
    check("rst_take_no_action", take_no_action, 0);
    check("rst_busy", busy, 0);
    check("rst_err_short", err_short, 0);

    // Channel 2: shift in all ones, then commit. A shift_en issued together
    // with update_dr must be ignored.
    cyc(0, 0, 0, 0, 1, 2'd2);
    check("ir_q_2", ir_q, 2);
    cyc(1, 0, 0, 0, 0, '0);
    check("busy_in_shift", busy, 1);
    for (int i = 0; i < DR_W; i++) cyc(0, 1, 0, 1, 0, '0);
    push(4'b0100, 4'b0000, ONES, exp_err);
    cyc(0, 1, 1, 0, 0, '0);
    idle(3);
    check("busy_after_commit", busy, 0);

    // Channel 1: serial read-out of the capture word, then a read-only commit.
    cyc(0, 0, 0, 0, 1, 2'd1);
    cyc(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < DR_W; i++) begin
      cyc(0, 1, 0, 0, 0, '0);
      stream[i] = tdo;
    end
    check("tdo_stream", stream, CH1);
    push(4'b0000, 4'b0010, '0, exp_err);
    cyc(0, 0, 1, 0, 0, '0);
    idle(3);

    // Channel 3: short scan of 10 bits.
    cyc(0, 0, 0, 0, 1, 2'd3);
    cyc(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1, 0, '0);
`ifdef DEBUG_SLAVE_CTRL_SCAN_CHECK_EN
    exp_err = 1'b1;
    push(4'b0000, 4'b0000, 38'h3F_F000_0000, exp_err);
`else
    push(4'b1000, 4'b0000, 38'h3F_F000_0000, exp_err);
`endif
    cyc(0, 0, 1, 0, 0, '0);
    idle(3);
    check("err_short_sticky", err_short, exp_err);

    // Channel 0: capture_en with update_dr mid-scan recaptures without a commit.
    // An immediate commit then yields the untouched capture word.
    cyc(0, 0, 0, 0, 1, 2'd0);
    cyc(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, '0);
    cyc(1, 0, 1, 0, 0, '0);
    idle(2);
    check("busy_after_recapture", busy, 1);
`ifdef DEBUG_SLAVE_CTRL_SCAN_CHECK_EN
    push(4'b0000, 4'b0000, CH0, exp_err);
`else
    push(4'b0001, 4'b0000, CH0, exp_err);
`endif
    cyc(0, 0, 1, 0, 0, '0);
    idle(3);

    // Reset mid-shift: scan discarded, no pulse, everything cleared.
    cyc(0, 0, 0, 0, 1, 2'd1);
    cyc(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0, '0);
    exp_err = 1'b0;
    push(4'b0000, 4'b0000, '0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_jdo", jdo, 0);
    check("midrst_ir_q", ir_q, 0);
    check("midrst_err_short", err_short, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b0;
    idle(2);

    // Set up known non-zero jdo and tdo. Strobes in IDLE must then leave them
    // unchanged.
    cyc(0, 0, 0, 0, 1, 2'd0);
    cyc(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < DR_W; i++) cyc(0, 1, 0, 1, 0, '0);
    check("tdo_last_bit", tdo, CH0[DR_W-1]);
    push(4'b0001, 4'b0000, ONES, exp_err);
    cyc(0, 0, 1, 0, 0, '0);
    idle(3);
    cyc(0, 0, 1, 0, 0, '0);
    cyc(0, 1, 0, 0, 0, '0);
    idle(3);
    check("idle_jdo_held", jdo, ONES);
    check("idle_tdo_held", tdo, 1);
    check("idle_busy", busy, 0);

    idle(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_slave_ctrl.md
DEBUG_SLAVE_CTRL -- requirements
Module: debug_slave_ctrl

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 2: instruction register width.
REQ-002 SHALL have parameter DR_WIDTH, default 38: data shift register width, min 2.
REQ-003 SHALL have parameter NUM_CH, default 4: action channels, equal to 2**IR_WIDTH.
REQ-004 SHALL have port clk  input  1: single system clock, all logic rising-edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port ir_in  input  IR_WIDTH: instruction value sampled on update_ir.
REQ-007 SHALL have port update_ir  input  1: one-cycle strobe, latch ir_in.
REQ-008 SHALL have port capture_en  input  1: one-cycle strobe, load capture data.
REQ-009 SHALL have port shift_en  input  1: one-cycle strobe, shift one bit.
REQ-010 SHALL have port update_dr  input  1: one-cycle strobe, commit shifted word.
REQ-011 SHALL have port tdi  input  1: serial data in, valid with shift_en.
REQ-012 SHALL have port cap_data  input  NUM_CH*DR_WIDTH: per-channel capture words, channel k at bits [k*DR_WIDTH +: DR_WIDTH].
REQ-013 SHALL have port tdo  output  1: registered serial data out.
REQ-014 SHALL have port jdo  output  DR_WIDTH: last committed word.
REQ-015 SHALL have port ir_q  output  IR_WIDTH: latched instruction.
REQ-016 SHALL have port take_action  output  NUM_CH: one-hot one-cycle command pulse.
REQ-017 SHALL have port take_no_action  output  NUM_CH: one-hot one-cycle read-only pulse.
REQ-018 SHALL have port busy  output  1: high when state is not IDLE.
REQ-019 SHALL have port err_short  output  1: sticky short-scan flag.

Function
REQ-020 SHALL implement states IDLE, SHIFT, UPDATE; IDLE->SHIFT on capture_en; SHIFT->UPDATE on update_dr; UPDATE->IDLE after exactly one cycle.
REQ-021 SHALL latch ir_in into ir_q on update_ir in any state; new ir_q takes effect for the next capture_en.
REQ-022 On capture_en, SHALL load sr with cap_data slice selected by ir_q, clear bit counter, enter SHIFT; capture_en in SHIFT restarts capture.
REQ-023 On shift_en in SHIFT, SHALL set sr to {tdi, sr[DR_WIDTH-1:1]}, tdo to old sr[0], counter +1 saturating at DR_WIDTH.
REQ-024 SHALL ignore shift_en and update_dr in IDLE and UPDATE: no sr change, no pulses.
REQ-025 Simultaneous strobes priority: capture_en > update_dr > shift_en; update_ir always processed in parallel.
REQ-026 On SHIFT->UPDATE, SHALL load jdo with sr the next edge; in that same UPDATE cycle pulse take_action[ir_q] if sr[DR_WIDTH-1]=1, else take_no_action[ir_q].
REQ-027 Latency: update_dr sampled at edge N, jdo and pulse visible after edge N+1, held one cycle (pulse) / until next commit (jdo).
REQ-028 At most one bit of take_action|take_no_action SHALL be high in any cycle.

Reset
REQ-029 On reset SHALL force state IDLE, sr, counter, jdo, ir_q, tdo, take_action, take_no_action, busy, err_short to zero, immediately and asynchronously.
REQ-030 Reset mid-SHIFT or in UPDATE SHALL discard partial scan and suppress any pending pulse.

Configuration
REQ-031 Macro DEBUG_SLAVE_CTRL_SCAN_CHECK_EN defined: commit with counter < DR_WIDTH SHALL update jdo, suppress both pulses, set err_short; err_short clears only on reset.
REQ-032 Macro undefined: err_short SHALL be tied 0, counter logic omitted, every commit pulses per REQ-026 regardless of bit count.

Verification
REQ-033 reset release, no strobes for 10 cycles -> all outputs 0, busy 0.
REQ-034 update_ir ir_in=2, capture, 38 shifts of tdi=1, update_dr -> jdo=0x3F_FFFF_FFFF, take_action=4'b0100 for one cycle, busy low after.
REQ-035 cap_data ch1=0x15_5555_5555, ir_q=1, capture, 38 shifts tdi=0 -> tdo serial stream equals 0x15_5555_5555 LSB-first; update_dr -> take_no_action=4'b0010.
REQ-036 capture, 10 shifts, update_dr with macro defined -> no pulse, err_short=1; macro undefined -> pulse issued, err_short=0.
REQ-037 capture_en and update_dr same cycle in SHIFT -> recapture, no pulse, counter 0; reset asserted mid-shift -> no pulse, jdo=0.
REQ-038 update_dr while IDLE and shift_en while IDLE -> jdo, tdo, pulses unchanged.
